dll_dlcmsm: RTL

//  Data Link Control state machine and InitFC DLLP transmit scheduler for the DLL.

---
 rtl/dll_pkg.sv | 32 +++
 rtl/dll_initfc_scheduler.sv | 107 ++++++++++
 rtl/dll_dlcmsm.sv | 91 +++++++++
 3 files changed

// File: rtl/dll_pkg.sv
// Shared DLL definitions: DLC state encoding, InitFC DLLP type codes and the
// InitFC DLLP builder. The RX packet demux uses the same codes.
package dll_pkg;

  typedef enum logic [1:0] {
    DLC_DL_INACTIVE = 2'b00,
    DLC_DL_INIT1    = 2'b01,
    DLC_DL_INIT2    = 2'b10,
    DLC_DL_ACTIVE   = 2'b11
  } dlc_state_e;

  typedef enum logic [1:0] {
    SCH_IDLE = 2'b00,
    SCH_SEND = 2'b01,
    SCH_WAIT = 2'b10
  } sched_state_e;

  localparam logic [3:0] INITFC1_P   = 4'h4;
  localparam logic [3:0] INITFC1_NP  = 4'h5;
  localparam logic [3:0] INITFC1_CPL = 4'h6;
  localparam logic [3:0] INITFC2_P   = 4'hC;
  localparam logic [3:0] INITFC2_NP  = 4'hD;
  localparam logic [3:0] INITFC2_CPL = 4'hE;

  // VC0 only; the upper 16 bits stay zero because CRC is inserted downstream.
  function automatic logic [47:0] build_initfc(input logic [3:0]  dllp_type,
                                               input logic [7:0]  hdr,
                                               input logic [11:0] data);
    return {16'h0000, 4'h0, data, hdr, dllp_type, 4'h0};
  endfunction

endpackage

// File: rtl/dll_initfc_scheduler.sv
// Emits one InitFC P/NP/Cpl set per start, then repeats it after a resend gap
// until aborted. Holds the presented DLLP stable while the TX path stalls.
module dll_initfc_scheduler
  import dll_pkg::*;
#(
  parameter logic [7:0]  PH_CREDITS    = 8'd32,
  parameter logic [11:0] PD_CREDITS    = 12'd256,
  parameter logic [7:0]  NPH_CREDITS   = 8'd32,
  parameter logic [11:0] NPD_CREDITS   = 12'd64,
  parameter logic [7:0]  CPLH_CREDITS  = 8'd0,
  parameter logic [11:0] CPLD_CREDITS  = 12'd0,
  parameter int          RESEND_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  phase,
  input  logic        abort,
  input  logic        tx_dllp_ready_i,
  output logic [47:0] tx_dllp_o,
  output logic        tx_dllp_valid_o,
  output logic        set_done
);

  localparam int TW = $clog2(RESEND_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RESEND_CYCLES - 1);

  sched_state_e  sch_q, sch_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [47:0]   dllp_q, dllp_d;

  function automatic logic [47:0] initfc_dllp(input logic [1:0] ph, input logic [1:0] i);
    logic two;
    two = (ph == 2'd2);
    case (i)
      2'd0:    return build_initfc(two ? INITFC2_P : INITFC1_P, PH_CREDITS, PD_CREDITS);
      2'd1:    return build_initfc(two ? INITFC2_NP : INITFC1_NP, NPH_CREDITS, NPD_CREDITS);
      default: return build_initfc(two ? INITFC2_CPL : INITFC1_CPL, CPLH_CREDITS, CPLD_CREDITS);
    endcase
  endfunction

  // Kept independent of abort so the top-level transition logic has no loop.
  assign set_done = (sch_q == SCH_SEND) && tx_dllp_ready_i && (idx_q == 2'd2);

  always_comb begin
    sch_d   = sch_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    dllp_d  = dllp_q;
    if (abort) begin
      sch_d   = SCH_IDLE;
      idx_d   = 2'd0;
      timer_d = '0;
      dllp_d  = '0;
    end else if (start) begin
      sch_d   = SCH_SEND;
      idx_d   = 2'd0;
      timer_d = '0;
      dllp_d  = initfc_dllp(phase, 2'd0);
    end else begin
      case (sch_q)
        SCH_SEND: begin
          if (tx_dllp_ready_i) begin
            if (idx_q == 2'd2) begin
              sch_d   = SCH_WAIT;
              idx_d   = 2'd0;
              timer_d = '0;
              dllp_d  = '0;
            end else begin
              idx_d  = idx_q + 2'd1;
              dllp_d = initfc_dllp(phase, idx_q + 2'd1);
            end
          end
        end
        SCH_WAIT: begin
          if (timer_q >= TIMER_LAST) begin
            sch_d  = SCH_SEND;
            idx_d  = 2'd0;
            dllp_d = initfc_dllp(phase, 2'd0);
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sch_q   <= SCH_IDLE;
      idx_q   <= 2'd0;
      timer_q <= '0;
      dllp_q  <= '0;
    end else begin
      sch_q   <= sch_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      dllp_q  <= dllp_d;
    end
  end

  assign tx_dllp_o       = dllp_q;
  assign tx_dllp_valid_o = (sch_q == SCH_SEND);

endmodule

// File: rtl/dll_dlcmsm.sv
// Data Link Control state machine: walks the link through InitFC1/InitFC2 and
// drives the DLC state to the RX demux; DLLP emission lives in the scheduler.
module dll_dlcmsm
  import dll_pkg::*;
#(
  parameter logic [7:0]  PH_CREDITS    = 8'd32,
  parameter logic [11:0] PD_CREDITS    = 12'd256,
  parameter logic [7:0]  NPH_CREDITS   = 8'd32,
  parameter logic [11:0] NPD_CREDITS   = 12'd64,
  parameter logic [7:0]  CPLH_CREDITS  = 8'd0,
  parameter logic [11:0] CPLD_CREDITS  = 12'd0,
  parameter int          RESEND_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_up_i,
  input  logic        initfc1_done_i,
  input  logic        initfc2_done_i,
  output logic [1:0]  dlc_state_o,
  output logic        dl_up_o,
  output logic [47:0] tx_dllp_o,
  output logic        tx_dllp_valid_o,
  input  logic        tx_dllp_ready_i
);

  dlc_state_e state_q, state_d;
  logic       fc1_rx_q, fc2_rx_q, start_q;
  logic       set_done, abort;
  logic [1:0] phase;

  always_comb begin
    state_d = state_q;
    if (!link_up_i) begin
      state_d = DLC_DL_INACTIVE;
    end else begin
      case (state_q)
        DLC_DL_INACTIVE: state_d = DLC_DL_INIT1;
        DLC_DL_INIT1: if (set_done && (fc1_rx_q || initfc1_done_i)) state_d = DLC_DL_INIT2;
        DLC_DL_INIT2: if (set_done && (fc2_rx_q || initfc2_done_i)) state_d = DLC_DL_ACTIVE;
        default: ;
      endcase
    end
  end

  // Any state change restarts the scheduler and forgets received done pulses.
  assign abort = (state_d != state_q);
  assign phase = (state_q == DLC_DL_INIT2) ? 2'd2 : 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DLC_DL_INACTIVE;
      start_q  <= 1'b0;
      fc1_rx_q <= 1'b0;
      fc2_rx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= abort && ((state_d == DLC_DL_INIT1) || (state_d == DLC_DL_INIT2));
      if (abort) begin
        fc1_rx_q <= 1'b0;
        fc2_rx_q <= 1'b0;
      end else begin
        if ((state_q == DLC_DL_INIT1) && initfc1_done_i) fc1_rx_q <= 1'b1;
        if ((state_q == DLC_DL_INIT2) && initfc2_done_i) fc2_rx_q <= 1'b1;
      end
    end
  end

  dll_initfc_scheduler #(
    .PH_CREDITS   (PH_CREDITS),
    .PD_CREDITS   (PD_CREDITS),
    .NPH_CREDITS  (NPH_CREDITS),
    .NPD_CREDITS  (NPD_CREDITS),
    .CPLH_CREDITS (CPLH_CREDITS),
    .CPLD_CREDITS (CPLD_CREDITS),
    .RESEND_CYCLES(RESEND_CYCLES)
  ) u_sched (
    .clk            (clk),
    .rst            (rst),
    .start          (start_q),
    .phase          (phase),
    .abort          (abort),
    .tx_dllp_ready_i(tx_dllp_ready_i),
    .tx_dllp_o      (tx_dllp_o),
    .tx_dllp_valid_o(tx_dllp_valid_o),
    .set_done       (set_done)
  );

  assign dlc_state_o = state_q;
  assign dl_up_o     = (state_q == DLC_DL_ACTIVE);

endmodule
